idelay_sweep_ctrl: RTL and testbench

Parametrised multi-channel controller for variable-load-pipe input delay elements. It holds a shadow delay value per channel and issues per-channel pipeline-load (LDPIPEEN) strobes plus a broadcast set (LD) strobe. It also runs an autonomous per-channel delay sweep with a measurement handshake, for read-levelling and eye-centre calibration. It sits between the calibration sequencer / register interface and an array of delay primitive wrappers; `dly_val`, `dly_ld` and `dly_set` connect straight to their delay, load-pipe and set inputs.

---
 rtl/idelay_sweep_ctrl_pkg.sv | 28 ++
 rtl/idelay_sweep_ctrl_if.sv | 44 ++++
 rtl/idelay_sweep_ctrl_settle_timer.sv | 32 +++
 rtl/idelay_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_idelay_sweep_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idelay_sweep_ctrl_pkg.sv
// Shared definitions for the input-delay sweep controller.
//   - FSM state encodings (3-bit, kept as plain constants so older
//     tooling and waveform decoders can match on raw values)
//   - clog2 / ch_width helpers used to size channel-select fields
package idelay_ctrl_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SET      = 3'd1;
   localparam logic [2:0] ST_SETTLE   = 3'd2;
   localparam logic [2:0] ST_LOAD     = 3'd3;
   localparam logic [2:0] ST_SWSET    = 3'd4;
   localparam logic [2:0] ST_SWSETTLE = 3'd5;
   localparam logic [2:0] ST_REPORT   = 3'd6;
   localparam logic [2:0] ST_FINISH   = 3'd7;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // A single-channel build still needs a 1-bit select field.
   function automatic int ch_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/idelay_sweep_ctrl_if.sv
// Host-side bus of the delay sweep controller: shadow writes, apply,
// sweep control and the measurement handshake.
//   master : calibration sequencer / register block
//   slave  : idelay_sweep_ctrl
// Handshake: step_valid is held high while a settled sweep point is
// waiting; the point is consumed in any cycle where step_valid and
// step_ack are both high (ack may already be high when valid rises).
interface idelay_sweep_ctrl_if
   import idelay_ctrl_pkg::*;
   #(parameter int NUM_CH = 8,
     parameter int DLY_WIDTH = 5) ();

   localparam int CH_W = ch_width(NUM_CH);

   logic                 wr_en;
   logic [CH_W-1:0]      wr_ch;
   logic [DLY_WIDTH-1:0] wr_val;
   logic                 wr_err;
   logic                 apply;
   logic                 sweep_start;
   logic [CH_W-1:0]      sweep_ch;
   logic [DLY_WIDTH-1:0] sweep_first;
   logic [DLY_WIDTH-1:0] sweep_last;
   logic [DLY_WIDTH-1:0] sweep_step;
   logic                 sweep_abort;
   logic                 step_valid;
   logic [DLY_WIDTH-1:0] step_val;
   logic                 step_ack;
   logic                 busy;
   logic                 done;

   modport master (
      output wr_en, wr_ch, wr_val, apply, sweep_start, sweep_ch,
             sweep_first, sweep_last, sweep_step, sweep_abort, step_ack,
      input  wr_err, step_valid, step_val, busy, done
   );

   modport slave (
      input  wr_en, wr_ch, wr_val, apply, sweep_start, sweep_ch,
             sweep_first, sweep_last, sweep_step, sweep_abort, step_ack,
      output wr_err, step_valid, step_val, busy, done
   );

endinterface

// File: rtl/idelay_sweep_ctrl_settle_timer.sv
// idelay_settle_timer: loadable down-counter with a terminal pulse.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (wins over counting)
//   load_val  : number of cycles to count
//   tc        : high for the single cycle in which the count is 1,
//               i.e. the last of load_val cycles after the load cycle
module idelay_settle_timer
   import idelay_ctrl_pkg::*;
   #(parameter int CNT_W = 8)
   (
      input  logic             clk,
      input  logic             rst,
      input  logic             load,
      input  logic [CNT_W-1:0] load_val,
      output logic             tc
   );

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == CNT_W'(1));

endmodule

// File: rtl/idelay_sweep_ctrl.sv
// idelay_sweep_ctrl: per-channel shadow delay values for load-pipe delay
// primitives, with host writes, a broadcast apply, and an autonomous
// single-channel delay sweep with a measurement handshake.
//   clk, rst   : clock, synchronous active-high reset
//   host       : host bus (slave side), see idelay_sweep_ctrl_if
//   dly_val    : shadow values, channel n at [n*DLY_WIDTH +: DLY_WIDTH]
//   dly_ld     : per-channel load-pipe strobe, coincident with new dly_val
//   dly_set    : broadcast set strobe
//   state_dbg  : current FSM state encoding
module idelay_sweep_ctrl
   import idelay_ctrl_pkg::*;
   #(parameter int NUM_CH        = 8,
     parameter int DLY_WIDTH     = 5,
     parameter int DELAY_INIT    = 0,
     parameter int SETTLE_CYCLES = 4)
   (
      input  logic                        clk,
      input  logic                        rst,
      idelay_sweep_ctrl_if.slave          host,
      output logic [NUM_CH*DLY_WIDTH-1:0] dly_val,
      output logic [NUM_CH-1:0]           dly_ld,
      output logic                        dly_set,
      output logic [2:0]                  state_dbg
   );

   localparam int CH_W = ch_width(NUM_CH);
   localparam int CH_SPACE = 1 << CH_W;

   logic [2:0]           state, state_nx;
   logic [DLY_WIDTH-1:0] shadow [NUM_CH];
   logic [DLY_WIDTH-1:0] v;
   logic [CH_W-1:0]      sw_ch;
   logic [DLY_WIDTH-1:0] sw_last, sw_step;
   logic                 sw_up;
   logic [NUM_CH-1:0]    ld_q;
   logic                 wr_err_q;
   logic [CH_SPACE-1:0]  ch_ok;

   logic                 sweep_active;
   logic [DLY_WIDTH-1:0] remaining, v_adv;
   logic                 has_next;
   logic                 timer_load, timer_tc;
   logic                 wr_ok;
   logic [CH_W-1:0]      load_ch;
   logic [DLY_WIDTH-1:0] load_v;

   // Marks which select codes name a real channel; avoids a compare that
   // is constant when NUM_CH is a power of two.
   always_comb begin
      ch_ok = '0;
      for (int i = 0; i < CH_SPACE; i++) ch_ok[i] = (i < NUM_CH);
   end

   assign sweep_active = (state == ST_LOAD) || (state == ST_SWSET) ||
                         (state == ST_SWSETTLE) || (state == ST_REPORT);

   // Next point exists only while the distance to the end point still
   // covers a full step, so the sweep neither overshoots nor wraps.
   assign remaining = sw_up ? (sw_last - v) : (v - sw_last);
   assign has_next  = (remaining >= sw_step);
   assign v_adv     = sw_up ? (v + sw_step) : (v - sw_step);

   assign wr_ok = ch_ok[host.wr_ch] && !(sweep_active && (host.wr_ch == sw_ch));

   always_comb begin
      state_nx   = state;
      timer_load = 1'b0;
      case (state)
         ST_IDLE: begin
            if (host.sweep_start)  state_nx = ST_LOAD;
            else if (host.apply)   state_nx = ST_SET;
         end
         ST_SET: begin
            timer_load = 1'b1;
            state_nx   = ST_SETTLE;
         end
         ST_SETTLE:   if (timer_tc) state_nx = ST_FINISH;
         ST_LOAD:     state_nx = ST_SWSET;
         ST_SWSET: begin
            timer_load = 1'b1;
            state_nx   = ST_SWSETTLE;
         end
         ST_SWSETTLE: if (timer_tc) state_nx = ST_REPORT;
         ST_REPORT:   if (host.step_ack) state_nx = has_next ? ST_LOAD : ST_FINISH;
         ST_FINISH:   state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
      if (sweep_active && host.sweep_abort) state_nx = ST_FINISH;
   end

   // Entering LOAD either starts a sweep (values from the host) or
   // advances it (values from the latched sweep context).
   assign load_ch = (state == ST_IDLE) ? host.sweep_ch    : sw_ch;
   assign load_v  = (state == ST_IDLE) ? host.sweep_first : v_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         v        <= '0;
         sw_ch    <= '0;
         sw_last  <= '0;
         sw_step  <= '0;
         sw_up    <= 1'b0;
         ld_q     <= '0;
         wr_err_q <= 1'b0;
         for (int n = 0; n < NUM_CH; n++) shadow[n] <= DLY_WIDTH'(DELAY_INIT);
      end else begin
         state    <= state_nx;
         ld_q     <= '0;
         wr_err_q <= 1'b0;
         if (host.wr_en) begin
            if (wr_ok) begin
               shadow[host.wr_ch] <= host.wr_val;
               ld_q[host.wr_ch]   <= 1'b1;
            end else begin
               wr_err_q <= 1'b1;
            end
         end
         if (state == ST_IDLE && host.sweep_start) begin
            sw_ch   <= host.sweep_ch;
            sw_last <= host.sweep_last;
            sw_step <= (host.sweep_step == '0) ? DLY_WIDTH'(1) : host.sweep_step;
            sw_up   <= (host.sweep_last >= host.sweep_first);
         end
         // Sweep load is placed after the host write so it wins if both
         // target the same channel in the start cycle.
         if (state_nx == ST_LOAD) begin
            v <= load_v;
            if (ch_ok[load_ch]) begin
               shadow[load_ch] <= load_v;
               ld_q[load_ch]   <= 1'b1;
            end
         end
      end
   end

   idelay_settle_timer #(.CNT_W(8)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (8'(SETTLE_CYCLES)),
      .tc       (timer_tc)
   );

   for (genvar n = 0; n < NUM_CH; n++) begin : g_pack
      assign dly_val[n*DLY_WIDTH +: DLY_WIDTH] = shadow[n];
   end

   assign dly_ld          = ld_q;
   assign dly_set         = (state == ST_SET) || (state == ST_SWSET);
   assign state_dbg       = state;
   assign host.wr_err     = wr_err_q;
   assign host.step_valid = (state == ST_REPORT);
   assign host.step_val   = v;
   assign host.busy       = (state != ST_IDLE) && (state != ST_FINISH);
   assign host.done       = (state == ST_FINISH);

endmodule

// File: tb/tb_idelay_sweep_ctrl.sv
module tb_idelay_sweep_ctrl;

   localparam int NCH = 8;
   localparam int W   = 5;
   localparam int S   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NCH*W-1:0] dly_val;
   logic [NCH-1:0]   dly_ld;
   logic             dly_set;
   logic [2:0]       state_dbg;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];

   idelay_sweep_ctrl_if #(.NUM_CH(NCH), .DLY_WIDTH(W)) bus ();

   idelay_sweep_ctrl #(.NUM_CH(NCH), .DLY_WIDTH(W), .DELAY_INIT(0), .SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .host      (bus),
      .dly_val   (dly_val),
      .dly_ld    (dly_ld),
      .dly_set   (dly_set),
      .state_dbg (state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] dval(input int ch);
      return dly_val[ch*W +: W];
   endfunction

   // driver tasks
   task automatic drive_idle();
      bus.wr_en = 0; bus.wr_ch = '0; bus.wr_val = '0; bus.apply = 0;
      bus.sweep_start = 0; bus.sweep_ch = '0; bus.sweep_first = '0;
      bus.sweep_last = '0; bus.sweep_step = '0; bus.sweep_abort = 0; bus.step_ack = 0;
   endtask

   task automatic start_sweep(input int ch, input int first, input int last, input int step);
      bus.sweep_ch = 3'(ch); bus.sweep_first = W'(first);
      bus.sweep_last = W'(last); bus.sweep_step = W'(step);
      bus.sweep_start = 1;
      tick();
      bus.sweep_start = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1;
      repeat (3) tick();
      rst = 0;
      total++;
      if ({dly_ld, dly_set, bus.wr_err, bus.step_valid, bus.busy, bus.done} !== '0) begin
         bad++; $display("FAIL reset_strobes: got %b want 0", {dly_ld, dly_set, bus.wr_err, bus.step_valid, bus.busy, bus.done});
      end
      total++;
      if (dly_val !== '0 || bus.step_val !== '0 || state_dbg !== 3'd0) begin
         bad++; $display("FAIL reset_values: got val=%h sv=%h st=%0d want 0", dly_val, bus.step_val, state_dbg);
      end
   endtask

   task automatic test_write();
      logic [NCH*W-1:0] e;
      bus.wr_en = 1; bus.wr_ch = 3'd3; bus.wr_val = 5'd17;
      tick();
      bus.wr_en = 0;
      e = '0; e[3*W +: W] = 5'd17;
      total++;
      if (dly_val !== e || dly_ld !== 8'h08) begin
         bad++; $display("FAIL write_ch3: got val=%h ld=%h want val=%h ld=08", dly_val, dly_ld, e);
      end
      tick();
      total++;
      if (dly_ld !== 8'h00 || bus.wr_err !== 1'b0) begin
         bad++; $display("FAIL write_ld_pulse: got ld=%h err=%b want 00 0", dly_ld, bus.wr_err);
      end
   endtask

   task automatic test_back_to_back();
      bus.wr_en = 1; bus.wr_ch = 3'd7; bus.wr_val = 5'd31;
      tick();
      total++;
      if (dval(7) !== 5'd31 || dly_ld !== 8'h80) begin
         bad++; $display("FAIL b2b_first: got v7=%0d ld=%h want 31 80", dval(7), dly_ld);
      end
      bus.wr_ch = 3'd0; bus.wr_val = 5'd1;
      tick();
      bus.wr_en = 0;
      total++;
      if (dval(0) !== 5'd1 || dly_ld !== 8'h01 || dval(7) !== 5'd31 || dval(3) !== 5'd17) begin
         bad++; $display("FAIL b2b_second: got v0=%0d ld=%h v7=%0d v3=%0d want 1 01 31 17", dval(0), dly_ld, dval(7), dval(3));
      end
      tick();
   endtask

   task automatic test_apply();
      bus.apply = 1;
      tick();
      bus.apply = 0;
      total++;
      if (dly_set !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         bad++; $display("FAIL apply_set: got set=%b busy=%b done=%b want 1 1 0", dly_set, bus.busy, bus.done);
      end
      for (int i = 2; i <= S + 1; i++) begin
         tick();
         total++;
         if (dly_set !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++; $display("FAIL apply_settle%0d: got set=%b busy=%b done=%b want 0 1 0", i, dly_set, bus.busy, bus.done);
         end
      end
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL apply_done: got done=%b busy=%b want 1 0", bus.done, bus.busy);
      end
      tick();
      total++;
      if (bus.done !== 1'b0 || state_dbg !== 3'd0) begin
         bad++; $display("FAIL apply_idle: got done=%b st=%0d want 0 0", bus.done, state_dbg);
      end
   endtask

   // Runs a sweep with immediate acks against the points queued in exp_q.
   task automatic run_sweep(input string name, input int ch, input int first, input int last, input int step);
      logic [W-1:0] e;
      int guard;
      guard = 0;
      start_sweep(ch, first, last, step);
      while (exp_q.size() > 0 && guard < 16) begin
         e = exp_q.pop_front();
         guard++;
         total++;
         if (dly_ld !== (8'b1 << ch) || dval(ch) !== e || bus.busy !== 1'b1) begin
            bad++; $display("FAIL %s_load: got ld=%h val=%0d busy=%b want ld=%h val=%0d", name, dly_ld, dval(ch), bus.busy, 8'b1 << ch, e);
         end
         tick();
         total++;
         if (dly_set !== 1'b1 || dly_ld !== 8'h00) begin
            bad++; $display("FAIL %s_set: got set=%b ld=%h want 1 00 (point %0d)", name, dly_set, dly_ld, e);
         end
         for (int i = 0; i < S; i++) begin
            tick();
            total++;
            if (bus.step_valid !== 1'b0) begin
               bad++; $display("FAIL %s_settle: got valid=%b want 0 (point %0d)", name, bus.step_valid, e);
            end
         end
         tick();
         total++;
         if (bus.step_valid !== 1'b1 || bus.step_val !== e) begin
            bad++; $display("FAIL %s_report: got valid=%b val=%0d want 1 %0d", name, bus.step_valid, bus.step_val, e);
         end
         bus.step_ack = 1;
         tick();
         bus.step_ack = 0;
      end
      total++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || dly_ld !== 8'h00) begin
         bad++; $display("FAIL %s_done: got done=%b busy=%b ld=%h want 1 0 00", name, bus.done, bus.busy, dly_ld);
      end
      tick();
      total++;
      if (bus.done !== 1'b0 || state_dbg !== 3'd0) begin
         bad++; $display("FAIL %s_idle: got done=%b st=%0d want 0 0", name, bus.done, state_dbg);
      end
   endtask

   task automatic test_sweep();
      exp_q = '{5'd2, 5'd5, 5'd8, 5'd11};
      run_sweep("up_exact", 2, 2, 11, 3);
      exp_q = '{5'd2, 5'd5, 5'd8};
      run_sweep("up_short", 2, 2, 10, 3);
      total++;
      if (dval(2) !== 5'd8) begin
         bad++; $display("FAIL up_short_final: got %0d want 8", dval(2));
      end
      exp_q = '{5'd20, 5'd12, 5'd4};
      run_sweep("down", 1, 20, 4, 8);
      exp_q = '{5'd7};
      run_sweep("single_step0", 6, 7, 7, 0);
   endtask

   task automatic test_sweep_write();
      start_sweep(5, 3, 3, 1);
      repeat (S + 2) tick();
      total++;
      if (bus.step_valid !== 1'b1 || bus.step_val !== 5'd3) begin
         bad++; $display("FAIL sw_wr_report: got valid=%b val=%0d want 1 3", bus.step_valid, bus.step_val);
      end
      bus.wr_en = 1; bus.wr_ch = 3'd5; bus.wr_val = 5'd9;
      tick();
      total++;
      if (bus.wr_err !== 1'b1 || dval(5) !== 5'd3 || dly_ld !== 8'h00) begin
         bad++; $display("FAIL sw_wr_reject: got err=%b v5=%0d ld=%h want 1 3 00", bus.wr_err, dval(5), dly_ld);
      end
      bus.wr_ch = 3'd1; bus.wr_val = 5'd6;
      tick();
      bus.wr_en = 0;
      total++;
      if (bus.wr_err !== 1'b0 || dval(1) !== 5'd6 || dly_ld !== 8'h02) begin
         bad++; $display("FAIL sw_wr_other: got err=%b v1=%0d ld=%h want 0 6 02", bus.wr_err, dval(1), dly_ld);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (bus.step_valid !== 1'b1 || bus.step_val !== 5'd3 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL sw_hold%0d: got valid=%b val=%0d busy=%b want 1 3 1", i, bus.step_valid, bus.step_val, bus.busy);
         end
      end
      bus.step_ack = 1;
      tick();
      bus.step_ack = 0;
      total++;
      if (bus.done !== 1'b1 || bus.step_valid !== 1'b0) begin
         bad++; $display("FAIL sw_hold_done: got done=%b valid=%b want 1 0", bus.done, bus.step_valid);
      end
      tick();
   endtask

   task automatic test_abort();
      start_sweep(0, 1, 9, 4);
      repeat (S + 2) tick();
      total++;
      if (bus.step_valid !== 1'b1 || bus.step_val !== 5'd1) begin
         bad++; $display("FAIL abort_report: got valid=%b val=%0d want 1 1", bus.step_valid, bus.step_val);
      end
      bus.sweep_abort = 1;
      tick();
      bus.sweep_abort = 0;
      total++;
      if (bus.done !== 1'b1 || bus.step_valid !== 1'b0 || bus.busy !== 1'b0 || dval(0) !== 5'd1) begin
         bad++; $display("FAIL abort_done: got done=%b valid=%b busy=%b v0=%0d want 1 0 0 1", bus.done, bus.step_valid, bus.busy, dval(0));
      end
      tick();
      total++;
      if (bus.done !== 1'b0 || state_dbg !== 3'd0) begin
         bad++; $display("FAIL abort_idle: got done=%b st=%0d want 0 0", bus.done, state_dbg);
      end
   endtask

   task automatic test_reset_mid_sweep();
      start_sweep(4, 10, 20, 5);
      tick();
      tick();
      total++;
      if (state_dbg !== 3'd5) begin
         bad++; $display("FAIL rst_mid_state: got %0d want 5", state_dbg);
      end
      rst = 1;
      tick();
      rst = 0;
      total++;
      if ({dly_ld, dly_set, bus.wr_err, bus.step_valid, bus.busy, bus.done} !== '0 || bus.step_val !== '0) begin
         bad++; $display("FAIL rst_mid_outputs: got %b sv=%0d want 0", {dly_ld, dly_set, bus.wr_err, bus.step_valid, bus.busy, bus.done}, bus.step_val);
      end
      total++;
      if (dly_val !== '0) begin
         bad++; $display("FAIL rst_mid_shadow: got %h want 0", dly_val);
      end
      for (int i = 0; i < S + 4; i++) begin
         tick();
         total++;
         if (bus.done !== 1'b0 || state_dbg !== 3'd0) begin
            bad++; $display("FAIL rst_mid_nodone%0d: got done=%b st=%0d want 0 0", i, bus.done, state_dbg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_back_to_back();
      test_apply();
      test_sweep();
      test_sweep_write();
      test_abort();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
